// File: rtl/rc4_ksa_engine_if.sv
// Control handshake and S-RAM port bundle for rc4_ksa_engine.
// cycle_count exists only when RC4_KSA_PERF_CNT_EN is defined.
interface rc4_ksa_engine_if #(
  parameter int DATA_WIDTH = 8,
  parameter int KEY_BYTES  = 3
);
  logic                    start;
  logic                    init_only;
  logic [KEY_BYTES*8-1:0]  key;
  logic                    busy;
  logic                    done;
  logic                    wren;
  logic [DATA_WIDTH-1:0]   address;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH-1:0]   q;
`ifdef RC4_KSA_PERF_CNT_EN
  logic [31:0]             cycle_count;

  modport master (output start, init_only, key, q,
                  input  busy, done, wren, address, data, cycle_count);
  modport slave  (input  start, init_only, key, q,
                  output busy, done, wren, address, data, cycle_count);
`else
  modport master (output start, init_only, key, q,
                  input  busy, done, wren, address, data);
  modport slave  (input  start, init_only, key, q,
                  output busy, done, wren, address, data);
`endif
endinterface

// File: rtl/rc4_ksa_engine.sv
// RC4 key-scheduling engine (init + shuffle) driving an external single-port S RAM.
// Define RC4_KSA_PERF_CNT_EN to add the saturating busy-cycle counter cycle_count.
module rc4_ksa_engine #(
  parameter int DATA_WIDTH   = 8,
  parameter int KEY_BYTES    = 3,
  parameter int READ_LATENCY = 1
) (
  input  logic            clk,
  input  logic            reset,
  rc4_ksa_engine_if.slave bus
);
  localparam int              KI_W     = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KI_W-1:0] KEY_LAST = KI_W'(KEY_BYTES - 1);
  localparam logic [1:0]      LAT_LAST = 2'(READ_LATENCY - 1);

  typedef enum logic [2:0] {IDLE, INIT, RD_I, RD_J, WR_I, WR_J, DONE} state_t;

  state_t                   state_q, state_d;
  logic [DATA_WIDTH-1:0]    i_q, i_d, j_q, j_d, si_q, si_d;
  logic [KI_W-1:0]          key_idx_q, key_idx_d;
  logic [1:0]               lat_q, lat_d;
  logic [KEY_BYTES-1:0][7:0] key_q, key_d;
  logic                     init_only_q, init_only_d;
  logic                     busy_q, busy_d, done_q, done_d, wren_q, wren_d;
  logic [DATA_WIDTH-1:0]    address_q, address_d, data_q, data_d;
  logic [7:0]               key_byte;
  logic                     i_last, lat_last;

  // Byte 0 of the key sits in the top byte lane.
  assign key_byte = key_q[KEY_LAST - key_idx_q];
  assign i_last   = (i_q == '1);
  assign lat_last = (lat_q == LAT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    si_d        = si_q;
    key_idx_d   = key_idx_q;
    lat_d       = lat_q;
    key_d       = key_q;
    init_only_d = init_only_q;
    case (state_q)
      IDLE: if (bus.start) begin
        key_d       = bus.key;
        init_only_d = bus.init_only;
        i_d         = '0;
        j_d         = '0;
        key_idx_d   = '0;
        state_d     = INIT;
      end
      // i doubles as the init write counter and wraps to 0 for the shuffle.
      INIT: begin
        i_d   = i_q + 1'b1;
        lat_d = '0;
        if (i_last) state_d = init_only_q ? DONE : RD_I;
      end
      RD_I: if (lat_last) begin
        si_d    = bus.q;
        j_d     = j_q + bus.q + DATA_WIDTH'(key_byte);
        lat_d   = '0;
        state_d = RD_J;
      end else lat_d = lat_q + 1'b1;
      RD_J: if (lat_last) state_d = WR_I;
            else          lat_d   = lat_q + 1'b1;
      WR_I: state_d = WR_J;
      WR_J: begin
        i_d       = i_q + 1'b1;
        key_idx_d = (key_idx_q == KEY_LAST) ? '0 : key_idx_q + 1'b1;
        lat_d     = '0;
        state_d   = i_last ? DONE : RD_I;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from next-cycle values so every port comes straight off a flop.
  always_comb begin
    busy_d    = 1'b0;
    done_d    = 1'b0;
    wren_d    = 1'b0;
    address_d = address_q;
    data_d    = data_q;
    case (state_d)
      INIT: begin busy_d = 1'b1; wren_d = 1'b1; address_d = i_d; data_d = i_d; end
      RD_I: begin busy_d = 1'b1; address_d = i_d; end
      RD_J: begin busy_d = 1'b1; address_d = j_d; end
      WR_I: begin busy_d = 1'b1; wren_d = 1'b1; address_d = i_d; data_d = bus.q; end
      WR_J: begin busy_d = 1'b1; wren_d = 1'b1; address_d = j_d; data_d = si_d; end
      DONE: done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_q         <= '0;
      j_q         <= '0;
      si_q        <= '0;
      key_idx_q   <= '0;
      lat_q       <= '0;
      key_q       <= '0;
      init_only_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wren_q      <= 1'b0;
      address_q   <= '0;
      data_q      <= '0;
    end else begin
      i_q         <= i_d;
      j_q         <= j_d;
      si_q        <= si_d;
      key_idx_q   <= key_idx_d;
      lat_q       <= lat_d;
      key_q       <= key_d;
      init_only_q <= init_only_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wren_q      <= wren_d;
      address_q   <= address_d;
      data_q      <= data_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.wren    = wren_q;
  assign bus.address = address_q;
  assign bus.data    = data_q;

`ifdef RC4_KSA_PERF_CNT_EN
  logic [31:0] cycle_count_q, cycle_count_d;

  always_comb begin
    cycle_count_d = cycle_count_q;
    if (state_q == IDLE && bus.start)          cycle_count_d = '0;
    else if (busy_q && cycle_count_q != '1)    cycle_count_d = cycle_count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cycle_count_q <= '0;
    else       cycle_count_q <= cycle_count_d;
  end

  assign bus.cycle_count = cycle_count_q;
`endif
endmodule

// File: tb/tb_rc4_ksa_engine.sv
// Directed bench for rc4_ksa_engine: three configurations, behavioural S RAMs,
// write-trace log and a software RC4 KSA reference.
`timescale 1ns/1ps
module tb_rc4_ksa_engine;
  logic clk;
  logic reset;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   t0;
  int   exp_s [256];

  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  logic [3:0] mem_c [16];
  logic [3:0] c_p1, c_p2;
  int         wa_addr [$];
  int         wa_data [$];
  int         wa_cyc  [$];

  rc4_ksa_engine_if #(.DATA_WIDTH(8), .KEY_BYTES(3)) ifa ();
  rc4_ksa_engine_if #(.DATA_WIDTH(8), .KEY_BYTES(5)) ifb ();
  rc4_ksa_engine_if #(.DATA_WIDTH(4), .KEY_BYTES(3)) ifc ();

  rc4_ksa_engine #(.DATA_WIDTH(8), .KEY_BYTES(3), .READ_LATENCY(1)) u_a (.clk(clk), .reset(reset), .bus(ifa));
  rc4_ksa_engine #(.DATA_WIDTH(8), .KEY_BYTES(5), .READ_LATENCY(1)) u_b (.clk(clk), .reset(reset), .bus(ifb));
  rc4_ksa_engine #(.DATA_WIDTH(4), .KEY_BYTES(3), .READ_LATENCY(3)) u_c (.clk(clk), .reset(reset), .bus(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Latency-1 RAMs: read data is valid for capture at the edge after the address appears.
  assign ifa.q = mem_a[ifa.address];
  assign ifb.q = mem_b[ifb.address];
  always @(posedge clk) begin
    if (ifa.wren) mem_a[ifa.address] <= ifa.data;
    if (ifb.wren) mem_b[ifb.address] <= ifb.data;
  end

  // Latency-3 RAM: two extra register stages behind the array read.
  assign ifc.q = c_p2;
  always @(posedge clk) begin
    if (ifc.wren) mem_c[ifc.address] <= ifc.data;
    c_p1 <= mem_c[ifc.address];
    c_p2 <= c_p1;
  end

  always @(negedge clk) if (ifa.wren === 1'b1) begin
    wa_addr.push_back(int'(ifa.address));
    wa_data.push_back(int'(ifa.data));
    wa_cyc.push_back(cyc);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic ksa_model(input int dw, input int kb, input logic [39:0] key);
    int n, j, t;
    logic [7:0] kbyte;
    n = 1 << dw;
    j = 0;
    for (int k = 0; k < n; k++) exp_s[k] = k;
    for (int i = 0; i < n; i++) begin
      kbyte = key[kb*8-1-8*(i%kb) -: 8];
      j = (j + exp_s[i] + int'(kbyte)) % n;
      t = exp_s[i]; exp_s[i] = exp_s[j]; exp_s[j] = t;
    end
  endtask

  function automatic int s_mism(input int which, input int n);
    int m;
    logic [7:0] v;
    m = 0;
    for (int k = 0; k < n; k++) begin
      case (which)
        0:       v = mem_a[k];
        1:       v = mem_b[k];
        default: v = {4'b0000, mem_c[k]};
      endcase
      if (v !== 8'(exp_s[k])) m++;
    end
    return m;
  endfunction

  function automatic int last_wr_cyc();
    if (wa_cyc.size() == 0) return -100;
    return wa_cyc[wa_cyc.size()-1];
  endfunction

  task automatic kick(input int which, input logic [39:0] key, input logic io);
    @(posedge clk); #1;
    wa_addr.delete(); wa_data.delete(); wa_cyc.delete();
    case (which)
      0:       begin ifa.start = 1'b1; ifa.key = key[23:0]; ifa.init_only = io; end
      1:       begin ifb.start = 1'b1; ifb.key = key;       ifb.init_only = io; end
      default: begin ifc.start = 1'b1; ifc.key = key[23:0]; ifc.init_only = io; end
    endcase
    @(posedge clk); #1;
    t0 = cyc;
    ifa.start = 1'b0; ifb.start = 1'b0; ifc.start = 1'b0;
  endtask

  // Entered in cycle 1 of a run; returns the cycle number in which done is seen (-1 on timeout).
  task automatic wait_done(input int which, input int poke_at, output int lat);
    logic d;
    lat = -1;
    for (int n = 1; n <= 4000; n++) begin
      d = (which == 0) ? ifa.done : (which == 1) ? ifb.done : ifc.done;
      if (d === 1'b1) begin lat = n; break; end
      if (n == poke_at) ifa.start = 1'b1;
      @(posedge clk); #1;
      ifa.start = 1'b0;
    end
  endtask

  initial begin
    int lat, bad, nw;
    int ea [6];
    int ed [6];
    ea = '{0, 0, 1, 1, 2, 3};
    ed = '{0, 0, 1, 1, 3, 2};
    reset = 1'b0;
    ifa.start = 1'b0; ifa.init_only = 1'b0; ifa.key = '0;
    ifb.start = 1'b0; ifb.init_only = 1'b0; ifb.key = '0;
    ifc.start = 1'b0; ifc.init_only = 1'b0; ifc.key = '0;
    #2 reset = 1'b1;
    #1;
    check("rst_busy",    32'(ifa.busy),    0);
    check("rst_done",    32'(ifa.done),    0);
    check("rst_wren",    32'(ifa.wren),    0);
    check("rst_address", 32'(ifa.address), 0);
    check("rst_data",    32'(ifa.data),    0);
    check("rst_c_busy",  32'(ifc.busy),    0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // init_only: identity fill in 256 consecutive cycles, then done.
    kick(0, 40'h0, 1'b1);
    check("io_busy_c1",  32'(ifa.busy), 1);
    check("io_first_wr", {23'd0, ifa.wren, ifa.address}, {23'd0, 1'b1, 8'h00});
    wait_done(0, 0, lat);
    check("io_done_cycle", lat, 257);
    check("io_wr_count", wa_addr.size(), 256);
    bad = 0;
    for (int k = 0; k < wa_addr.size(); k++)
      if (wa_addr[k] != k || wa_data[k] != k || wa_cyc[k] != t0 + k) bad++;
    check("io_wr_seq", bad, 0);
    check("io_done_after_wr", cyc - last_wr_cyc(), 1);
    check("io_busy_at_done", 32'(ifa.busy), 0);
    for (int k = 0; k < 256; k++) exp_s[k] = k;
    check("io_s_ident", s_mism(0, 256), 0);

    // key 0, with a stray start mid-shuffle and another on the DONE cycle.
    ksa_model(8, 3, 40'h0);
    kick(0, 40'h0, 1'b0);
    wait_done(0, 700, lat);
    check("k0_done_cycle", lat, 1281);
    check("k0_wr_count", wa_addr.size(), 768);
    for (int p = 0; p < 6; p++) begin
      check($sformatf("k0_swap_addr%0d", p), (wa_addr.size() > 256 + p) ? wa_addr[256+p] : -1, ea[p]);
      check($sformatf("k0_swap_data%0d", p), (wa_data.size() > 256 + p) ? wa_data[256+p] : -1, ed[p]);
    end
    check("k0_done_after_wr", cyc - last_wr_cyc(), 1);
    check("k0_s_model", s_mism(0, 256), 0);
`ifdef RC4_KSA_PERF_CNT_EN
    check("k0_cycle_count", ifa.cycle_count, 1280);
`endif
    ifa.start = 1'b1;
    @(posedge clk); #1;
    ifa.start = 1'b0;
    nw = wa_addr.size();
    repeat (3) @(posedge clk);
    #1;
    check("done_start_busy", 32'(ifa.busy), 0);
    check("done_start_wr",   wa_addr.size(), nw);

    // Multi-byte key exercising every key_idx value.
    ksa_model(8, 3, 40'h0103FF);
    kick(0, 40'h0103FF, 1'b0);
    wait_done(0, 0, lat);
    check("k0103ff_done_cycle", lat, 1281);
    check("k0103ff_s_model", s_mism(0, 256), 0);

    // Abort in RD_J of i=100 (cycle 258 + 4*100).
    kick(0, 40'h123456, 1'b0);
    repeat (657) @(posedge clk);
    #1;
    check("abort_pre_wren",  32'(ifa.wren), 0);
    check("abort_pre_busy",  32'(ifa.busy), 1);
    check("abort_pre_wrcnt", wa_addr.size(), 456);
    reset = 1'b1;
    #1;
    check("abort_wren", 32'(ifa.wren), 0);
    check("abort_busy", 32'(ifa.busy), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    ksa_model(8, 3, 40'h000001);
    kick(0, 40'h000001, 1'b0);
    wait_done(0, 0, lat);
    check("post_abort_done_cycle", lat, 1281);
    check("post_abort_s_model", s_mism(0, 256), 0);

    // Five-byte key.
    ksa_model(8, 5, 40'h0102030405);
    kick(1, 40'h0102030405, 1'b0);
    wait_done(1, 0, lat);
    check("kb5_done_cycle", lat, 1281);
    check("kb5_s_model", s_mism(1, 256), 0);

    // 4-bit S-box, read latency 3: 16 + 16*8 + 1.
    ksa_model(4, 3, 40'h0A0B0C);
    kick(2, 40'h0A0B0C, 1'b0);
    wait_done(2, 0, lat);
    check("l3_done_cycle", lat, 145);
    check("l3_s_model", s_mism(2, 16), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
